// File: rtl/acc_power_pkg.sv
// Shared widths, operand sequencing constants and FSM encoding for the
// E/P/L power stage that follows the tracking-channel accumulators.
package acc_power_pkg;

  localparam int ACC_WIDTH_DEF = 16;
  localparam int POW_WIDTH_DEF = 2 * ACC_WIDTH_DEF;

  // Squarer operand order: I_E, Q_E, I_P, Q_P, I_L, Q_L
  localparam int              IDX_WIDTH = 3;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/acc_power_square_reg.sv
// Registered signed squarer; kept on its own so the multiply maps onto a
// single DSP block with its output register absorbed.
module square_reg #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [W-1:0]  operand,
  output logic [2*W-1:0]       square
);

  logic signed [2*W-1:0] product;

  assign product = operand * operand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      square <= '0;
    end else if (clear) begin
      square <= '0;
    end else if (en) begin
      square <= $unsigned(product);
    end
  end

endmodule

// File: rtl/acc_power.sv
// Snapshots the six E/P/L accumulations on acc_complete and produces
// I^2+Q^2 per tap through one time-shared squarer, handed off via valid/ready.
module acc_power
  import acc_power_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int POW_WIDTH = 2 * ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        acc_complete,
  input  logic signed [ACC_WIDTH-1:0] acc_i_early,
  input  logic signed [ACC_WIDTH-1:0] acc_q_early,
  input  logic signed [ACC_WIDTH-1:0] acc_i_prompt,
  input  logic signed [ACC_WIDTH-1:0] acc_q_prompt,
  input  logic signed [ACC_WIDTH-1:0] acc_i_late,
  input  logic signed [ACC_WIDTH-1:0] acc_q_late,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [POW_WIDTH-1:0]        power_early,
  output logic [POW_WIDTH-1:0]        power_prompt,
  output logic [POW_WIDTH-1:0]        power_late,
  output logic signed [ACC_WIDTH-1:0] i_prompt_out,
  output logic signed [ACC_WIDTH-1:0] q_prompt_out,
  output logic                        overrun
);

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic signed [ACC_WIDTH-1:0] snap_ie, snap_qe, snap_ip, snap_qp, snap_il, snap_ql;
  logic [POW_WIDTH-1:0]   sum;
  logic [POW_WIDTH-1:0]   pend_early;
  logic [POW_WIDTH-1:0]   pend_prompt;

  logic signed [ACC_WIDTH-1:0] operand;
  logic [2*ACC_WIDTH-1:0] square;
  logic [POW_WIDTH-1:0]   acc_sum;
  logic                   consume;
  logic [IDX_WIDTH-1:0]   cidx;

  always_comb begin
    operand = '0;
    case (idx)
      3'd0:    operand = snap_ie;
      3'd1:    operand = snap_qe;
      3'd2:    operand = snap_ip;
      3'd3:    operand = snap_qp;
      3'd4:    operand = snap_il;
      3'd5:    operand = snap_ql;
      default: operand = '0;
    endcase
  end

  // The squarer output always belongs to the operand issued one edge earlier
  assign consume = ((state == SQUARE) && (idx != '0)) || (state == DONE);
  assign cidx    = idx - 3'd1;
  assign acc_sum = sum + POW_WIDTH'(square);

  square_reg #(.W(ACC_WIDTH)) u_square (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .en      (state == SQUARE),
    .operand (operand),
    .square  (square)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      snap_ie      <= '0;
      snap_qe      <= '0;
      snap_ip      <= '0;
      snap_qp      <= '0;
      snap_il      <= '0;
      snap_ql      <= '0;
      sum          <= '0;
      pend_early   <= '0;
      pend_prompt  <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      power_early  <= '0;
      power_prompt <= '0;
      power_late   <= '0;
      i_prompt_out <= '0;
      q_prompt_out <= '0;
      overrun      <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      idx          <= '0;
      snap_ie      <= '0;
      snap_qe      <= '0;
      snap_ip      <= '0;
      snap_qp      <= '0;
      snap_il      <= '0;
      snap_ql      <= '0;
      sum          <= '0;
      pend_early   <= '0;
      pend_prompt  <= '0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      power_early  <= '0;
      power_prompt <= '0;
      power_late   <= '0;
      i_prompt_out <= '0;
      q_prompt_out <= '0;
      overrun      <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Even operands start a tap sum, odd operands close it
      if (consume) begin
        if (!cidx[0]) begin
          sum <= POW_WIDTH'(square);
        end else begin
          case (cidx)
            3'd1:    pend_early  <= acc_sum;
            3'd3:    pend_prompt <= acc_sum;
            default: ;
          endcase
        end
      end

      case (state)
        IDLE: begin
          if (acc_complete) begin
            snap_ie <= acc_i_early;
            snap_qe <= acc_q_early;
            snap_ip <= acc_i_prompt;
            snap_qp <= acc_q_prompt;
            snap_il <= acc_i_late;
            snap_ql <= acc_q_late;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= SQUARE;
          end
        end
        SQUARE: begin
          if (acc_complete) begin
            overrun <= 1'b1;
          end
          idx <= idx + 3'd1;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (acc_complete) begin
            overrun <= 1'b1;
          end
          // An unacknowledged previous set is overwritten here
          if (out_valid && !out_ready) begin
            overrun <= 1'b1;
          end
          power_early  <= pend_early;
          power_prompt <= pend_prompt;
          power_late   <= acc_sum;
          i_prompt_out <= snap_ip;
          q_prompt_out <= snap_qp;
          out_valid    <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_power.sv
// Scoreboard bench for acc_power: the driver queues expected result sets,
// a forked monitor checks each accepted set and its latency.
module tb_acc_power;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        acc_complete = 1'b0;
  logic [15:0] acc_i_early = '0, acc_q_early = '0;
  logic [15:0] acc_i_prompt = '0, acc_q_prompt = '0;
  logic [15:0] acc_i_late = '0, acc_q_late = '0;
  logic        busy, out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] power_early, power_prompt, power_late;
  logic [15:0] i_prompt_out, q_prompt_out;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] pe, pp, pl;
    logic [15:0] ip, qp;
    int          issue;
    bit          lat_chk;
  } exp_t;

  exp_t sb[$];

  acc_power dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .acc_complete (acc_complete),
    .acc_i_early  (acc_i_early),
    .acc_q_early  (acc_q_early),
    .acc_i_prompt (acc_i_prompt),
    .acc_q_prompt (acc_q_prompt),
    .acc_i_late   (acc_i_late),
    .acc_q_late   (acc_q_late),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .power_early  (power_early),
    .power_prompt (power_prompt),
    .power_late   (power_late),
    .i_prompt_out (i_prompt_out),
    .q_prompt_out (q_prompt_out),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pwr(input logic [15:0] i, input logic [15:0] q);
    longint a, b;
    a = longint'($signed(i));
    b = longint'($signed(q));
    return 32'(a * a + b * b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=timeout required=event at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one acc_complete pulse; the sampling edge is the next posedge
  task automatic applyStimulus(input logic [15:0] ie, input logic [15:0] qe,
                               input logic [15:0] ip, input logic [15:0] qp,
                               input logic [15:0] il, input logic [15:0] ql,
                               input bit push, input bit lat_chk);
    exp_t e;
    acc_i_early  = ie; acc_q_early  = qe;
    acc_i_prompt = ip; acc_q_prompt = qp;
    acc_i_late   = il; acc_q_late   = ql;
    acc_complete = 1'b1;
    if (push) begin
      e.pe = pwr(ie, qe);
      e.pp = pwr(ip, qp);
      e.pl = pwr(il, ql);
      e.ip = ip;
      e.qp = qp;
      e.issue = cyc + 1;
      e.lat_chk = lat_chk;
      sb.push_back(e);
    end
    tick();
    acc_complete = 1'b0;
  endtask

  task automatic drain(input bit rand_ready, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
    out_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    if (!out_valid) fail_now("wait_valid");
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    check("power_early", 64'(power_early), 64'(e.pe));
    check("power_prompt", 64'(power_prompt), 64'(e.pp));
    check("power_late", 64'(power_late), 64'(e.pl));
    check("i_prompt_out", 64'(i_prompt_out), 64'(e.ip));
    check("q_prompt_out", 64'(q_prompt_out), 64'(e.qp));
  endtask

  task automatic monitor();
    bit prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid && !prev_valid && sb.size() != 0 && sb[0].lat_chk)
          check("latency", 64'(cyc - sb[0].issue), 64'd7);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", 64'(out_valid), 64'd0);
          end else begin
            checkOutput(sb[0]);
            void'(sb.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    check("reset_power_early", 64'(power_early), 64'd0);

    // Basic squares
    out_ready = 1'b1;
    applyStimulus(16'd3, -16'sd4, 16'd100, 16'd0, -16'sd1, -16'sd1, 1'b1, 1'b1);
    check("busy_after_start", 64'(busy), 64'd1);
    out_ready = 1'b1;
    drain(1'b0, 40);
    check("basic_overrun", 64'(overrun), 64'd0);

    // Extremes
    applyStimulus(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1);
    drain(1'b0, 40);
    check("extreme_overrun", 64'(overrun), 64'd0);

    // Stall for 20 cycles with outputs held
    out_ready = 1'b0;
    applyStimulus(16'd1234, -16'sd567, -16'sd32767, 16'd32767, 16'd7, -16'sd9, 1'b1, 1'b1);
    wait_valid(20);
    for (int s = 0; s < 20; s++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      if (sb.size() != 0) checkOutput(sb[0]);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_valid", 64'(out_valid), 64'd0);
    check("stall_popped", 64'(sb.size()), 64'd0);

    // Busy collision
    out_ready = 1'b1;
    applyStimulus(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 1'b1, 1'b1);
    tick(); tick();
    applyStimulus(16'd999, 16'd999, 16'd999, 16'd999, 16'd999, 16'd999, 1'b0, 1'b0);
    drain(1'b0, 40);
    check("collision_overrun", 64'(overrun), 64'd1);
    applyStimulus(-16'sd2, 16'd2, 16'd5, -16'sd5, 16'd0, 16'd1, 1'b1, 1'b1);
    drain(1'b0, 40);
    check("overrun_sticky", 64'(overrun), 64'd1);
    pulse_clear();
    check("clear_overrun", 64'(overrun), 64'd0);

    // Unconsumed overwrite
    out_ready = 1'b0;
    applyStimulus(16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 1'b0, 1'b0);
    repeat (9) tick();
    applyStimulus(-16'sd21, 16'd22, -16'sd23, 16'd24, -16'sd25, 16'd26, 1'b1, 1'b0);
    repeat (7) tick();
    check("overwrite_valid", 64'(out_valid), 64'd1);
    check("overwrite_overrun", 64'(overrun), 64'd1);
    drain(1'b0, 20);
    pulse_clear();

    // Overwrite with acknowledge on the completion edge
    out_ready = 1'b0;
    applyStimulus(16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 16'd36, 1'b1, 1'b1);
    repeat (9) tick();
    applyStimulus(16'd41, -16'sd42, 16'd43, -16'sd44, 16'd45, -16'sd46, 1'b1, 1'b0);
    repeat (6) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ack_overwrite_valid", 64'(out_valid), 64'd1);
    check("ack_overwrite_overrun", 64'(overrun), 64'd0);
    drain(1'b0, 20);

    // Reset mid-computation
    applyStimulus(16'd77, 16'd78, 16'd79, 16'd80, 16'd81, 16'd82, 1'b0, 1'b0);
    tick(); tick();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_valid", 64'(out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_power_early", 64'(power_early), 64'd0);
    check("midreset_i_prompt", 64'(i_prompt_out), 64'd0);
    tick(); tick();
    reset = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tick();
      check("midreset_no_valid", 64'(out_valid), 64'd0);
    end
    applyStimulus(-16'sd100, 16'd200, 16'd300, -16'sd400, 16'd500, -16'sd600, 1'b1, 1'b1);
    drain(1'b0, 40);

    // Randomized sets with random back-pressure
    for (int n = 0; n < 25; n++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
      drain(1'b1, 300);
      repeat ($urandom_range(0, 3)) tick();
    end
    check("random_overrun", 64'(overrun), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_power.md
Name: acc_power

Overview:
- Sits directly downstream of the early/prompt/late subchannel trio in a tracking channel.
- On the shared accumulation-complete pulse it snapshots all six signed I/Q accumulations and computes E/P/L power (I^2+Q^2) with one time-shared registered squarer.
- Presents the results plus a prompt I/Q snapshot to the tracking-loop/MCU interface through a valid/ready handshake.

Parameters:
- ACC_WIDTH, 16, width of each signed two's-complement accumulator input.
- POW_WIDTH, 2*ACC_WIDTH, width of each unsigned power output; exact, cannot overflow.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; same effect as reset, applied on the clock edge.
- acc_complete  in  1  one-cycle pulse: all six accumulator inputs are valid this cycle.
- acc_i_early, acc_q_early  in  ACC_WIDTH each  signed early accumulations.
- acc_i_prompt, acc_q_prompt  in  ACC_WIDTH each  signed prompt accumulations.
- acc_i_late, acc_q_late  in  ACC_WIDTH each  signed late accumulations.
- busy  out  1  high while a computation is in flight.
- out_valid  out  1  result set is available.
- out_ready  in  1  consumer accepts the result set.
- power_early, power_prompt, power_late  out  POW_WIDTH each  unsigned I^2+Q^2.
- i_prompt_out, q_prompt_out  out  ACC_WIDTH each  prompt snapshot matching the powers.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset / clear: all outputs and registers go to 0; FSM goes to IDLE.
- FSM states: IDLE, SQUARE, DONE.
- IDLE:
  - acc_complete=1 loads all six inputs into snapshot registers at edge k; FSM -> SQUARE at edge k.
  - Square index goes to 0 and busy=1 from edge k.
- SQUARE:
  - The squarer takes operand idx 0..5, one per edge k+1..k+6, in order I_E, Q_E, I_P, Q_P, I_L, Q_L.
  - Squarer output is registered (1-cycle latency). Product of idx n is available after edge k+n+1.
  - The running sum adds each product on edges k+2..k+7.
  - Even idx: sum loads the product. Odd idx: sum + product is written to the pending power register for that tap.
  - After edge k+7: FSM -> DONE.
- DONE (same edge k+7):
  - Pending powers and prompt snapshot copy to the output registers.
  - out_valid=1, busy=0, FSM -> IDLE.
  - Total latency: out_valid high 7 edges after the acc_complete sampling edge.
- Handshake:
  - out_valid holds, with outputs stable, until a cycle with out_valid&out_ready; out_valid falls on that edge.
  - out_ready while out_valid=0 is ignored.
- Arithmetic:
  - Squares are signed x*x, held as unsigned 2*ACC_WIDTH bits.
  - Worst case (-2^(ACC_WIDTH-1))^2 * 2 = 2^(2*ACC_WIDTH-1) fits POW_WIDTH. No saturation logic.
- acc_complete while busy: ignored (the snapshot is not disturbed); overrun is set.
- Completion while out_valid is still pending (unconsumed): new results overwrite the outputs, out_valid stays 1, overrun is set.
  - If out_ready is high on that same edge, it acknowledges the old set; the new set is presented and overrun is not set.
- acc_complete in the same cycle as the out_valid&out_ready acknowledge: both are honoured independently.
- overrun clears only on reset/clear.
- Reset asserted mid-computation: immediate return to IDLE; no partial result is ever presented.
- clear takes priority over acc_complete in the same cycle.

Decomposition:
- acc_power.vh holds:
  - default ACC_WIDTH/POW_WIDTH macros, with range macros in the style of the existing `*_RANGE` defines;
  - FSM state encodings;
  - the operand index width (3 bits) and the LAST_IDX=5 constant.
- One sub-module, square_reg:
  - signed ACC_WIDTH input, registered unsigned 2*ACC_WIDTH output;
  - async reset and clear;
  - isolated so synthesis maps it to a single DSP multiplier.

Test Plan:
- Basic squares: reset, then acc_complete with I_E=3, Q_E=-4, I_P=100, Q_P=0, I_L=-1, Q_L=-1, out_ready=1 -> out_valid exactly 7 edges later, powers 25 / 10000 / 2, i_prompt_out=100, q_prompt_out=0, overrun=0.
- Extremes: all six inputs = -32768 (ACC_WIDTH=16) -> each power = 2147483648 (0x80000000), no wrap.
- Stall: out_ready=0 for 20 cycles after out_valid -> outputs stable, out_valid held. Then out_ready=1 for one cycle -> out_valid falls on that edge.
- Busy collision: second acc_complete 3 cycles after the first -> ignored, results match the first set, overrun=1 and stays 1 until clear.
- Unconsumed overwrite: two sets 10 cycles apart with out_ready=0 -> outputs show the second set, overrun=1. Repeat with out_ready pulsed on the second completion edge -> overrun=0.
- Reset mid-operation: reset asserted at edge k+3 -> all outputs 0 asynchronously, out_valid never rises. A fresh acc_complete after release produces correct results.
